// File: rtl/fft_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fft_ctrl_pkg
// Shared types and helpers for the radix-2 DIT FFT sequencer.
//   state_e     : sequencer states (UNLOAD only used when FFT_CTRL_UNLOAD_EN
//                 is defined, but always declared so encodings stay stable)
//   pipe_depth  : read-to-write-back distance in cycles (RAM read + BFU)
//   bit_rev     : reverse the low n_log2 bits of a value
// No ports (package).
// ---------------------------------------------------------------------------
package fft_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_FIN    = 3'd3,
    ST_UNLOAD = 3'd4
  } state_e;

  // Largest supported log2 of the transform length.
  localparam int MAX_LOG2 = 12;

  // Total latency between a RAM read strobe and the matching BFU result.
  function automatic int pipe_depth(input int ram_lat, input int bfu_lat);
    return ram_lat + bfu_lat;
  endfunction

  // Reverses the low n_log2 bits of v; bits above n_log2 come back as 0.
  // Bits are shifted out of v LSB-first and into r, so the first bit taken
  // ends up as the most significant of the reversed field.
  function automatic logic [MAX_LOG2-1:0] bit_rev(input logic [MAX_LOG2-1:0] v,
                                                  input int n_log2);
    logic [MAX_LOG2-1:0] r;
    logic [MAX_LOG2-1:0] t;
    r = '0;
    t = v;
    for (int i = 0; i < MAX_LOG2; i++) begin
      if (i < n_log2) begin
        r = {r[MAX_LOG2-2:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_ctrl_dly.sv
// ---------------------------------------------------------------------------
// fft_ctrl_dly
// Fixed-depth shift register that carries the read strobe and operand
// addresses across the RAM + BFU pipeline so they re-emerge as the
// write-back strobe and addresses exactly DEPTH cycles later.
// Ports:
//   clk  in   clock
//   clr  in   asynchronous active-low reset (clears every stage)
//   d_i  in   W-bit word entering the pipe
//   q_o  out  W-bit word leaving the pipe, DEPTH cycles after d_i
// ---------------------------------------------------------------------------
module fft_ctrl_dly #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] sr_q [DEPTH];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/fft_ctrl.sv
// ---------------------------------------------------------------------------
// fft_ctrl
// Sequencer for an in-place radix-2 DIT FFT using one pipelined butterfly
// unit and a dual-port sample RAM. For each stage it streams HALF butterfly
// reads (operand addresses + twiddle index), then idles for PIPE cycles so
// the last write-back of the stage lands before the next stage reads.
// Write-back strobe/addresses are the read ones delayed by PIPE cycles.
//
// Optional build macro: FFT_CTRL_UNLOAD_EN
//   Adds an UNLOAD phase after the last stage that walks k = 0..N-1 and
//   presents RAM address bit_reverse(k), delaying done by N cycles.
//
// Ports:
//   clk          in   clock, rising edge
//   clr          in   asynchronous active-low reset
//   start        in   begin a transform (accepted in IDLE only)
//   busy         out  transform in progress
//   done         out  one-cycle completion pulse
//   stage        out  stage index currently issuing reads
//   rd_en        out  read strobe for both RAM ports
//   rd_addr_a/b  out  butterfly operand addresses
//   tw_addr      out  twiddle ROM index, aligned with rd_en
//   wr_en        out  write strobe for both RAM ports
//   wr_addr_a/b  out  write-back addresses
//   unld_en/unld_addr/unld_idx  out  (FFT_CTRL_UNLOAD_EN only) unload walk
//   dbg_state_o  out  current FSM state encoding
//
// Handshake: start is sampled on a rising edge while IDLE; busy rises the
// following cycle and stays high until the cycle done pulses, where it is
// already low. Any start seen outside IDLE is dropped, not queued.
// ---------------------------------------------------------------------------
module fft_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int N_LOG2  = 4,
  parameter int BFU_LAT = 3,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [N_LOG2-1:0] stage,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b,
`ifdef FFT_CTRL_UNLOAD_EN
  output logic              unld_en,
  output logic [N_LOG2-1:0] unld_addr,
  output logic [N_LOG2-1:0] unld_idx,
`endif
  output logic [2:0]        dbg_state_o
);

  localparam int PIPE = pipe_depth(RAM_LAT, BFU_LAT);
  localparam int HALF = 2 ** (N_LOG2 - 1);
  localparam int N    = 2 ** N_LOG2;
  localparam int JW   = N_LOG2 - 1;
  localparam int DCW  = $clog2(PIPE + 1);
  localparam int DW   = 1 + 2 * N_LOG2;

  localparam logic [JW-1:0]     J_LAST = JW'(HALF - 1);
  localparam logic [N_LOG2-1:0] S_ONE  = N_LOG2'(1);
  localparam logic [N_LOG2-1:0] LAST_S = N_LOG2'(N_LOG2 - 1);
  localparam logic [DCW-1:0]    D_LAST = DCW'(PIPE - 1);

  // FSM and counters
  state_e            state_q, state_d;
  logic [JW-1:0]     j_q, j_d;       // butterfly index within the stage
  logic [N_LOG2-1:0] s_q, s_d;       // stage index
  logic [DCW-1:0]    dcnt_q, dcnt_d; // drain cycle counter
`ifdef FFT_CTRL_UNLOAD_EN
  localparam logic [N_LOG2-1:0] K_LAST = N_LOG2'(N - 1);
  logic [N_LOG2-1:0] k_q, k_d;       // unload index
`endif

  // Registered read-side outputs and their next values
  logic              rd_en_q, rd_en_d;
  logic [N_LOG2-1:0] rd_a_q, rd_a_d;
  logic [N_LOG2-1:0] rd_b_q, rd_b_d;
  logic [JW-1:0]     tw_q, tw_d;

  // Address decode temporaries
  logic [JW-1:0]     pos_mask;
  logic [JW-1:0]     pos;
  logic [JW-1:0]     grp;

  logic [DW-1:0]     wb_word;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      s_q     <= '0;
      dcnt_q  <= '0;
`ifdef FFT_CTRL_UNLOAD_EN
      k_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      s_q     <= s_d;
      dcnt_q  <= dcnt_d;
`ifdef FFT_CTRL_UNLOAD_EN
      k_q     <= k_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    s_d     = s_q;
    dcnt_d  = dcnt_q;
`ifdef FFT_CTRL_UNLOAD_EN
    k_d     = k_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          j_d     = '0;
          s_d     = '0;
        end
      end
      ST_RUN: begin
        if (j_q == J_LAST) begin
          state_d = ST_DRAIN;
          dcnt_d  = '0;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      ST_DRAIN: begin
        // Exactly PIPE idle cycles: the last write of this stage happens in
        // the final drain cycle, so the next stage's first read follows it.
        if (dcnt_q == D_LAST) begin
          if (s_q == LAST_S) begin
`ifdef FFT_CTRL_UNLOAD_EN
            state_d = ST_UNLOAD;
            k_d     = '0;
`else
            state_d = ST_FIN;
`endif
          end else begin
            state_d = ST_RUN;
            s_d     = s_q + S_ONE;
            j_d     = '0;
          end
        end else begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end
      ST_UNLOAD: begin
`ifdef FFT_CTRL_UNLOAD_EN
        if (k_q == K_LAST) begin
          state_d = ST_FIN;
        end else begin
          k_d = k_q + N_LOG2'(1);
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        s_d     = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic
  // -------------------------------------------------------------------------
  always_comb begin
    busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN) ||
                  (state_q == ST_UNLOAD);
    done        = (state_q == ST_FIN);
    dbg_state_o = state_q;

    // Read addressing is decoded from the next-state counters and then
    // registered, so addresses appear in the same cycle as rd_en.
    // pos = j mod 2**s, grp = j >> s.
    rd_en_d  = (state_d == ST_RUN);
    pos_mask = {JW{1'b1}} >> (LAST_S - s_d);
    pos      = j_d & pos_mask;
    grp      = j_d >> s_d;
    rd_a_d   = (N_LOG2'(grp) << (s_d + S_ONE)) | N_LOG2'(pos);
    rd_b_d   = rd_a_d | (S_ONE << s_d);
    tw_d     = pos << (LAST_S - s_d);
    if (!rd_en_d) begin
      rd_a_d = '0;
      rd_b_d = '0;
      tw_d   = '0;
    end

`ifdef FFT_CTRL_UNLOAD_EN
    unld_en   = (state_q == ST_UNLOAD);
    unld_idx  = unld_en ? k_q : '0;
    unld_addr = unld_en ? N_LOG2'(bit_rev(MAX_LOG2'(k_q), N_LOG2)) : '0;
`endif
  end

  // Registered read-side outputs
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
    end else begin
      rd_en_q <= rd_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      tw_q    <= tw_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign tw_addr   = tw_q;
  assign stage     = s_q;

  // Write-back side: read strobe and addresses delayed by the RAM+BFU depth.
  fft_ctrl_dly #(
    .W     (DW),
    .DEPTH (PIPE)
  ) u_dly (
    .clk (clk),
    .clr (clr),
    .d_i ({rd_en_q, rd_a_q, rd_b_q}),
    .q_o (wb_word)
  );

  assign wr_en     = wb_word[DW-1];
  assign wr_addr_a = wb_word[2*N_LOG2-1:N_LOG2];
  assign wr_addr_b = wb_word[N_LOG2-1:0];

endmodule

// File: tb/tb_fft_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_ctrl
// Directed bench for fft_ctrl with N_LOG2=3 and default latencies.
// Expected reads/writes/done/busy samples are queued with the cycle at which
// they must appear; a negedge monitor pops and compares whenever the DUT
// presents an event. Cycle c0 is the cycle start is driven while IDLE.
// ---------------------------------------------------------------------------
module tb_fft_ctrl;

  localparam int NL        = 3;
  localparam int PIPE      = 4;
  localparam int STAGE_LEN = 8;   // HALF + PIPE for N=8
`ifdef FFT_CTRL_UNLOAD_EN
  localparam int DONE_AT   = 33;
`else
  localparam int DONE_AT   = 25;
`endif
  localparam int BIG       = 1000000;

  // clock/reset
  logic clk   = 1'b0;
  logic clr   = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic          busy, done, rd_en, wr_en;
  logic [NL-1:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [NL-2:0] tw_addr;
  logic [2:0]    dbg_state;
`ifdef FFT_CTRL_UNLOAD_EN
  logic          unld_en;
  logic [NL-1:0] unld_addr, unld_idx;
`endif

  fft_ctrl #(.N_LOG2(NL), .BFU_LAT(3), .RAM_LAT(1)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .stage       (stage),
    .rd_en       (rd_en),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .tw_addr     (tw_addr),
    .wr_en       (wr_en),
    .wr_addr_a   (wr_addr_a),
    .wr_addr_b   (wr_addr_b),
`ifdef FFT_CTRL_UNLOAD_EN
    .unld_en     (unld_en),
    .unld_addr   (unld_addr),
    .unld_idx    (unld_idx),
`endif
    .dbg_state_o (dbg_state)
  );

  // Hand-computed read table for N=8: {stage, a, b, tw}
  int rd_tab [12][4] = '{
    '{0, 0, 1, 0}, '{0, 2, 3, 0}, '{0, 4, 5, 0}, '{0, 6, 7, 0},
    '{1, 0, 2, 0}, '{1, 1, 3, 2}, '{1, 4, 6, 0}, '{1, 5, 7, 2},
    '{2, 0, 4, 0}, '{2, 1, 5, 1}, '{2, 2, 6, 2}, '{2, 3, 7, 3}
  };
  int unld_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  // scoreboard
  logic [42:0] rd_exp_q[$];    // {cycle, stage, a, b, tw}
  logic [37:0] wr_exp_q[$];    // {cycle, a, b}
  logic [31:0] done_exp_q[$];  // {cycle}
  logic [33:0] prb_exp_q[$];   // {cycle, busy, done}
  logic [37:0] unld_exp_q[$];  // {cycle, idx, addr}

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue everything a transform started at c0 should produce up to cycle last.
  task automatic push_transform(input int c0, input int last);
    int rc;
    for (int r = 0; r < 12; r++) begin
      rc = c0 + 1 + (r / 4) * STAGE_LEN + (r % 4);
      if (rc <= last)
        rd_exp_q.push_back({32'(rc), 3'(rd_tab[r][0]), 3'(rd_tab[r][1]),
                            3'(rd_tab[r][2]), 2'(rd_tab[r][3])});
      if (rc + PIPE <= last)
        wr_exp_q.push_back({32'(rc + PIPE), 3'(rd_tab[r][1]), 3'(rd_tab[r][2])});
    end
`ifdef FFT_CTRL_UNLOAD_EN
    for (int k = 0; k < 8; k++) begin
      if (c0 + 25 + k <= last)
        unld_exp_q.push_back({32'(c0 + 25 + k), 3'(k), 3'(unld_tab[k])});
    end
`endif
    prb_exp_q.push_back({32'(c0), 1'b0, 1'b0});
    if (c0 + 1 <= last) prb_exp_q.push_back({32'(c0 + 1), 1'b1, 1'b0});
    if (c0 + DONE_AT - 1 <= last)
      prb_exp_q.push_back({32'(c0 + DONE_AT - 1), 1'b1, 1'b0});
    if (c0 + DONE_AT <= last) begin
      prb_exp_q.push_back({32'(c0 + DONE_AT), 1'b0, 1'b1});
      done_exp_q.push_back(32'(c0 + DONE_AT));
    end
  endtask

  // monitor
  logic [42:0] rd_e;
  logic [37:0] wr_e;
  logic [31:0] dn_e;
  logic [33:0] pr_e;
`ifdef FFT_CTRL_UNLOAD_EN
  logic [37:0] un_e;
`endif

  always @(negedge clk) begin
    if (rd_en) begin
      if (rd_exp_q.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
      else begin
        rd_e = rd_exp_q.pop_front();
        chk("rd", 64'({32'(cyc), stage, rd_addr_a, rd_addr_b, tw_addr}), 64'(rd_e));
      end
    end
    if (wr_en) begin
      if (wr_exp_q.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
      else begin
        wr_e = wr_exp_q.pop_front();
        chk("wr", 64'({32'(cyc), wr_addr_a, wr_addr_b}), 64'(wr_e));
      end
    end
    if (done) begin
      if (done_exp_q.size() == 0) chk("done_unexpected", 64'(cyc), 64'd0);
      else begin
        dn_e = done_exp_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(dn_e));
      end
    end
    if (prb_exp_q.size() > 0 && prb_exp_q[0][33:2] == 32'(cyc)) begin
      pr_e = prb_exp_q.pop_front();
      chk("busy_done", 64'({busy, done}), 64'(pr_e[1:0]));
    end
`ifdef FFT_CTRL_UNLOAD_EN
    if (unld_en) begin
      if (unld_exp_q.size() == 0) chk("unld_unexpected", 64'd1, 64'd0);
      else begin
        un_e = unld_exp_q.pop_front();
        chk("unld", 64'({32'(cyc), unld_idx, unld_addr}), 64'(un_e));
      end
    end
`endif
  end

  // stimulus
  int c0;
  initial begin
    #1 clr = 1'b0;
    tick(3);
    chk("rst_busy",  64'(busy),      64'd0);
    chk("rst_done",  64'(done),      64'd0);
    chk("rst_rd_en", 64'(rd_en),     64'd0);
    chk("rst_wr_en", 64'(wr_en),     64'd0);
    chk("rst_addr",  64'({stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    clr = 1'b1;
    tick(2);

    // single start pulse, plus a stray pulse mid-transform that must be ignored
    c0 = cyc;
    start = 1'b1;
    push_transform(c0, BIG);
    tick(1);
    start = 1'b0;
    tick(9);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(DONE_AT);

    // start held high: exactly one restart right after the FIN cycle
    c0 = cyc;
    start = 1'b1;
    push_transform(c0, BIG);
    push_transform(c0 + DONE_AT + 1, BIG);
    tick(DONE_AT + 2);
    start = 1'b0;
    tick(DONE_AT + 5);

    // reset mid-transform at relative cycle 12: everything drops, no done
    c0 = cyc;
    start = 1'b1;
    push_transform(c0, c0 + 11);
    tick(1);
    start = 1'b0;
    tick(11);
    clr = 1'b0;
    #1;
    chk("midrst_strobes", 64'({busy, done, rd_en, wr_en}), 64'd0);
    chk("midrst_addr", 64'({stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b}), 64'd0);
    tick(2);
    clr = 1'b1;
    tick(2);

    // full transform after the abandoned one
    c0 = cyc;
    start = 1'b1;
    push_transform(c0, BIG);
    tick(1);
    start = 1'b0;
    tick(DONE_AT + 5);

    // bounded wait for outstanding expectations, then report leftovers
    for (int i = 0; i < 100; i++) begin
      if (rd_exp_q.size() + wr_exp_q.size() + done_exp_q.size() +
          prb_exp_q.size() + unld_exp_q.size() == 0) break;
      tick(1);
    end
    chk("left_rd",   64'(rd_exp_q.size()),   64'd0);
    chk("left_wr",   64'(wr_exp_q.size()),   64'd0);
    chk("left_done", 64'(done_exp_q.size()), 64'd0);
    chk("left_prb",  64'(prb_exp_q.size()),  64'd0);
    chk("left_unld", 64'(unld_exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
